// File: rtl/rename_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : rename_regfile_if
// Purpose  : Issue, commit and source-lookup bundle for the rename register file.
// Revision : 1.0
// ============================================================================
interface rename_regfile_if #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = RW + 1;

    logic                      rdy_in;
    logic                      flush;
    logic [ISSUE_W-1:0]        iss_en;
    logic [ISSUE_W*RW-1:0]     iss_rd;
    logic [ISSUE_W*TAG_W-1:0]  iss_tag;
    logic [ISSUE_W*RW-1:0]     iss_rs1;
    logic [ISSUE_W*RW-1:0]     iss_rs2;
    logic [ISSUE_W*XLEN-1:0]   src1_val;
    logic [ISSUE_W*XLEN-1:0]   src2_val;
    logic [ISSUE_W*TAG_W-1:0]  src1_lab;
    logic [ISSUE_W*TAG_W-1:0]  src2_lab;
    logic [COMMIT_W-1:0]       cmt_en;
    logic [COMMIT_W*RW-1:0]    cmt_rd;
    logic [COMMIT_W*TAG_W-1:0] cmt_tag;
    logic [COMMIT_W*XLEN-1:0]  cmt_val;
    logic [CW-1:0]             pending_cnt;

    modport master (
        output rdy_in, flush, iss_en, iss_rd, iss_tag, iss_rs1, iss_rs2,
        output cmt_en, cmt_rd, cmt_tag, cmt_val,
        input  src1_val, src2_val, src1_lab, src2_lab, pending_cnt
    );

    modport slave (
        input  rdy_in, flush, iss_en, iss_rd, iss_tag, iss_rs1, iss_rs2,
        input  cmt_en, cmt_rd, cmt_tag, cmt_val,
        output src1_val, src2_val, src1_lab, src2_lab, pending_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rename_regfile.sv
`default_nettype none
// ============================================================================
// Module   : rename_regfile
// Purpose  : Architectural register file with ROB rename labels, multi-lane
//            rename lookup, commit forwarding and flush recovery.
// Revision : 1.0
// ============================================================================
module rename_regfile #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_in,
    rename_regfile_if.slave  bus
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = RW + 1;

    logic [XLEN-1:0]  r_value [NUM_REGS];
    logic [TAG_W-1:0] r_label [NUM_REGS];
    logic [CW-1:0]    r_pending;

    logic [XLEN-1:0]  w_next_value [NUM_REGS];
    logic [TAG_W-1:0] w_next_label [NUM_REGS];
    logic [CW-1:0]    w_cnt;
    logic             w_eff;

    assign w_eff = bus.rdy_in & ~bus.flush;

    // Lanes are scanned in program order so the highest matching lane wins.
    always_comb begin : p_next_state
        logic             l_cmt_hit;
        logic [TAG_W-1:0] l_cmt_tag;
        logic             l_iss_hit;
        logic [TAG_W-1:0] l_iss_tag;
        w_cnt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_next_value[r] = r_value[r];
            w_next_label[r] = r_label[r];
            l_cmt_hit = 1'b0;
            l_cmt_tag = '0;
            l_iss_hit = 1'b0;
            l_iss_tag = '0;
            if (r != 0 && w_eff) begin
                for (int c = 0; c < COMMIT_W; c++) begin
                    if (bus.cmt_en[c] && bus.cmt_rd[c*RW +: RW] == RW'(r)) begin
                        l_cmt_hit       = 1'b1;
                        l_cmt_tag       = bus.cmt_tag[c*TAG_W +: TAG_W];
                        w_next_value[r] = bus.cmt_val[c*XLEN +: XLEN];
                    end
                end
                for (int i = 0; i < ISSUE_W; i++) begin
                    if (bus.iss_en[i] && bus.iss_rd[i*RW +: RW] == RW'(r)) begin
                        l_iss_hit = 1'b1;
                        l_iss_tag = bus.iss_tag[i*TAG_W +: TAG_W];
                    end
                end
                if (l_iss_hit) begin
                    w_next_label[r] = l_iss_tag;
                end else if (l_cmt_hit && r_label[r] == l_cmt_tag) begin
                    w_next_label[r] = '0;
                end
            end else if (r != 0 && bus.rdy_in && bus.flush) begin
                w_next_label[r] = '0;
            end
            if (w_next_label[r] != '0) begin
                w_cnt = w_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_value[r] <= '0;
                r_label[r] <= '0;
            end
            r_pending <= '0;
        end else if (bus.rdy_in) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_value[r] <= w_next_value[r];
                r_label[r] <= w_next_label[r];
            end
            r_pending <= w_cnt;
        end
    end

    assign bus.pending_cnt = r_pending;

    // Priority: x0, then older rename lane in the group, then commit forward, then storage.
    always_comb begin : p_lookup
        logic [RW-1:0]    l_s;
        logic [XLEN-1:0]  l_v;
        logic [TAG_W-1:0] l_l;
        bus.src1_val = '0;
        bus.src2_val = '0;
        bus.src1_lab = '0;
        bus.src2_lab = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int p = 0; p < 2; p++) begin
                l_s = (p == 0) ? bus.iss_rs1[k*RW +: RW] : bus.iss_rs2[k*RW +: RW];
                l_v = r_value[l_s];
                l_l = r_label[l_s];
                if (w_eff) begin
                    for (int c = 0; c < COMMIT_W; c++) begin
                        if (bus.cmt_en[c] && bus.cmt_rd[c*RW +: RW] == l_s) begin
                            l_v = bus.cmt_val[c*XLEN +: XLEN];
                            l_l = (r_label[l_s] == bus.cmt_tag[c*TAG_W +: TAG_W]) ?
                                  '0 : r_label[l_s];
                        end
                    end
                    for (int j = 0; j < k; j++) begin
                        if (bus.iss_en[j] && bus.iss_rd[j*RW +: RW] == l_s) begin
                            l_l = bus.iss_tag[j*TAG_W +: TAG_W];
                        end
                    end
                end
                if (l_s == '0) begin
                    l_v = '0;
                    l_l = '0;
                end
                if (p == 0) begin
                    bus.src1_val[k*XLEN +: XLEN]   = l_v;
                    bus.src1_lab[k*TAG_W +: TAG_W] = l_l;
                end else begin
                    bus.src2_val[k*XLEN +: XLEN]   = l_v;
                    bus.src2_lab[k*TAG_W +: TAG_W] = l_l;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rename_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_regfile
// Purpose  : Directed and randomized checks of rename_regfile against a
//            program-order behavioural model.
// Revision : 1.0
// ============================================================================
module tb_rename_regfile;
    logic clk;
    logic rst_in;
    int   n_chk  = 0;
    int   n_pass = 0;

    rename_regfile_if bus ();

    rename_regfile dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_val [32];
    logic [4:0]  m_lab [32];
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic void exp_src(input int k, input logic [4:0] s,
                                    output logic [31:0] v, output logic [4:0] l, output bit dc);
        bit eff = bus.rdy_in && !bus.flush;
        v  = m_val[s];
        l  = m_lab[s];
        dc = 0;
        if (s == 0) begin
            v = 0;
            l = 0;
            return;
        end
        if (eff) begin
            for (int c = 0; c < 2; c++)
                if (bus.cmt_en[c] && bus.cmt_rd[c*5 +: 5] == s) begin
                    v = bus.cmt_val[c*32 +: 32];
                    l = (m_lab[s] == bus.cmt_tag[c*5 +: 5]) ? 5'd0 : m_lab[s];
                end
            for (int j = 0; j < k; j++)
                if (bus.iss_en[j] && bus.iss_rd[j*5 +: 5] == s) begin
                    l  = bus.iss_tag[j*5 +: 5];
                    dc = 1;
                end
        end
    endfunction

    // Retire commits then renames in program order for one clock.
    function automatic void model_step();
        logic [4:0] nl [32];
        bit         clr [32];
        bit         iss [32];
        logic [4:0] rd;
        if (!bus.rdy_in) return;
        if (bus.flush) begin
            for (int r = 0; r < 32; r++) m_lab[r] = 0;
            m_cnt = 0;
            return;
        end
        for (int r = 0; r < 32; r++) begin
            nl[r]  = m_lab[r];
            clr[r] = 0;
            iss[r] = 0;
        end
        for (int c = 0; c < 2; c++) begin
            rd = bus.cmt_rd[c*5 +: 5];
            if (bus.cmt_en[c] && rd != 0) begin
                m_val[rd] = bus.cmt_val[c*32 +: 32];
                clr[rd]   = (m_lab[rd] == bus.cmt_tag[c*5 +: 5]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            rd = bus.iss_rd[i*5 +: 5];
            if (bus.iss_en[i] && rd != 0) begin
                nl[rd]  = bus.iss_tag[i*5 +: 5];
                iss[rd] = 1;
            end
        end
        m_cnt = 0;
        for (int r = 1; r < 32; r++) begin
            if (!iss[r] && clr[r]) nl[r] = 0;
            m_lab[r] = nl[r];
            if (nl[r] != 0) m_cnt++;
        end
    endfunction

    always @(negedge clk) begin
        logic [31:0] v;
        logic [4:0]  l;
        bit          dc;
        if (rst_in) begin
            for (int r = 0; r < 32; r++) begin
                m_val[r] = 0;
                m_lab[r] = 0;
            end
            m_cnt = 0;
        end
        for (int k = 0; k < 2; k++) begin
            exp_src(k, bus.iss_rs1[k*5 +: 5], v, l, dc);
            if (!dc) chk("model_src1_val", bus.src1_val[k*32 +: 32], v);
            chk("model_src1_lab", 32'(bus.src1_lab[k*5 +: 5]), 32'(l));
            exp_src(k, bus.iss_rs2[k*5 +: 5], v, l, dc);
            if (!dc) chk("model_src2_val", bus.src2_val[k*32 +: 32], v);
            chk("model_src2_lab", 32'(bus.src2_lab[k*5 +: 5]), 32'(l));
        end
        chk("model_pending", 32'(bus.pending_cnt), 32'(m_cnt));
        if (!rst_in) model_step();
    end

    task automatic idle();
        bus.rdy_in  = 1;
        bus.flush   = 0;
        bus.iss_en  = '0;
        bus.iss_rd  = '0;
        bus.iss_tag = '0;
        bus.iss_rs1 = '0;
        bus.iss_rs2 = '0;
        bus.cmt_en  = '0;
        bus.cmt_rd  = '0;
        bus.cmt_tag = '0;
        bus.cmt_val = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_iss(input int lane, input logic en, input logic [4:0] rd,
                           input logic [4:0] tag, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.iss_en[lane]          = en;
        bus.iss_rd[lane*5 +: 5]   = rd;
        bus.iss_tag[lane*5 +: 5]  = tag;
        bus.iss_rs1[lane*5 +: 5]  = rs1;
        bus.iss_rs2[lane*5 +: 5]  = rs2;
    endtask

    task automatic set_cmt(input int lane, input logic [4:0] rd, input logic [4:0] tag,
                           input logic [31:0] val);
        bus.cmt_en[lane]          = 1;
        bus.cmt_rd[lane*5 +: 5]   = rd;
        bus.cmt_tag[lane*5 +: 5]  = tag;
        bus.cmt_val[lane*32 +: 32] = val;
    endtask

    initial begin
        logic [4:0] rd;
        rst_in = 1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_in = 0;

        set_iss(0, 0, 0, 0, 5, 0);
        @(negedge clk);
        chk("reset_val", bus.src1_val[0 +: 32], 32'd0);
        chk("reset_lab", 32'(bus.src1_lab[0 +: 5]), 0);
        chk("reset_x0_lab", 32'(bus.src2_lab[0 +: 5]), 0);
        chk("reset_pending", 32'(bus.pending_cnt), 0);

        tick(); set_iss(0, 1, 3, 7, 0, 0); set_iss(1, 0, 0, 0, 3, 0);
        @(negedge clk);
        chk("intra_group_lab", 32'(bus.src1_lab[5 +: 5]), 7);
        tick(); set_iss(0, 0, 0, 0, 3, 0);
        @(negedge clk);
        chk("issued_lab", 32'(bus.src1_lab[0 +: 5]), 7);
        chk("issued_pending", 32'(bus.pending_cnt), 1);

        tick(); set_cmt(0, 3, 7, 32'hDEAD); set_iss(0, 0, 0, 0, 3, 0);
        @(negedge clk);
        chk("fwd_val", bus.src1_val[0 +: 32], 32'hDEAD);
        chk("fwd_lab", 32'(bus.src1_lab[0 +: 5]), 0);
        tick(); set_iss(0, 0, 0, 0, 3, 0);
        @(negedge clk);
        chk("cmt_val", bus.src1_val[0 +: 32], 32'hDEAD);
        chk("cmt_lab", 32'(bus.src1_lab[0 +: 5]), 0);
        chk("cmt_pending", 32'(bus.pending_cnt), 0);

        tick(); set_iss(0, 1, 4, 9, 0, 0);
        tick(); set_cmt(0, 4, 2, 5);
        tick(); set_iss(0, 0, 0, 0, 4, 0);
        @(negedge clk);
        chk("stale_cmt_val", bus.src1_val[0 +: 32], 5);
        chk("stale_cmt_lab", 32'(bus.src1_lab[0 +: 5]), 9);
        tick(); set_iss(0, 1, 4, 11, 0, 0); set_cmt(0, 4, 9, 6);
        tick(); set_iss(0, 0, 0, 0, 4, 0);
        @(negedge clk);
        chk("iss_cmt_val", bus.src1_val[0 +: 32], 6);
        chk("iss_cmt_lab", 32'(bus.src1_lab[0 +: 5]), 11);

        tick(); set_cmt(0, 6, 1, 1); set_cmt(1, 6, 1, 2);
        tick(); set_iss(0, 0, 0, 0, 6, 0);
        @(negedge clk);
        chk("two_cmt_val", bus.src1_val[0 +: 32], 2);
        tick(); set_iss(0, 1, 6, 3, 0, 0); set_iss(1, 1, 6, 4, 0, 0);
        tick(); set_iss(0, 0, 0, 0, 6, 0);
        @(negedge clk);
        chk("two_iss_lab", 32'(bus.src1_lab[0 +: 5]), 4);

        tick(); set_iss(0, 1, 10, 1, 0, 0); set_iss(1, 1, 11, 2, 0, 0);
        tick(); set_iss(0, 1, 12, 3, 0, 0);
        tick(); bus.rdy_in = 0; bus.flush = 1; set_cmt(0, 10, 1, 77); set_iss(0, 0, 0, 0, 10, 0);
        @(negedge clk);
        chk("five_pending", 32'(bus.pending_cnt), 5);
        chk("stall_val", bus.src1_val[0 +: 32], 0);
        chk("stall_lab", 32'(bus.src1_lab[0 +: 5]), 1);
        tick(); bus.flush = 1; set_cmt(0, 10, 1, 77); set_iss(0, 0, 0, 0, 10, 0);
        @(negedge clk);
        chk("stall_hold_pending", 32'(bus.pending_cnt), 5);
        chk("flush_nofwd_lab", 32'(bus.src1_lab[0 +: 5]), 1);
        tick(); set_iss(0, 0, 0, 0, 10, 3); set_iss(1, 0, 0, 0, 4, 0);
        @(negedge clk);
        chk("flush_pending", 32'(bus.pending_cnt), 0);
        chk("flush_drop_val", bus.src1_val[0 +: 32], 0);
        chk("flush_lab", 32'(bus.src1_lab[0 +: 5]), 0);
        chk("flush_keep_val", bus.src2_val[0 +: 32], 32'hDEAD);
        chk("flush_keep_val4", bus.src1_val[32 +: 32], 6);
        chk("flush_lab4", 32'(bus.src1_lab[5 +: 5]), 0);

        for (int n = 0; n < 1500; n++) begin
            tick();
            rst_in     = (n == 700);
            bus.rdy_in = ($urandom % 10) != 0;
            bus.flush  = ($urandom % 25) == 0;
            for (int i = 0; i < 2; i++)
                set_iss(i, 1'($urandom), 5'($urandom % 8), 5'($urandom_range(1, 31)),
                        5'($urandom % 8), 5'($urandom % 8));
            for (int c = 0; c < 2; c++) begin
                rd = 5'($urandom % 8);
                set_cmt(c, rd, ($urandom % 2) ? m_lab[rd] : 5'($urandom), $urandom);
                bus.cmt_en[c] = 1'($urandom);
            end
        end
        tick();
        rst_in = 0;
        @(negedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
